// File: rtl/ascon_permutation_iter_if.sv
// Shared state type and start/busy/done handshake bundle for the iterative ASCON permutation.
// The state is five 64-bit lanes, with x0 held in element [0].
package ascon_pack;
   typedef logic [4:0][63:0] type_state;
endpackage

interface ascon_permutation_iter_if;
   import ascon_pack::*;

   logic       start_i;
   logic [3:0] rounds_i;
   type_state  state_i;
   type_state  state_o;
   logic [3:0] round_o;
   logic       busy_o;
   logic       done_o;

   modport master (
      output start_i, rounds_i, state_i,
      input  state_o, round_o, busy_o, done_o
   );

   modport slave (
      input  start_i, rounds_i, state_i,
      output state_o, round_o, busy_o, done_o
   );
endinterface

// File: rtl/ascon_permutation_iter.sv
// Iterative ASCON permutation p^n with UNROLL chained rounds per clock.
// Rounds r = 12-n .. 11 are applied; the result is held until the next accepted start.
module ascon_permutation_iter
   import ascon_pack::*;
#(
   parameter int UNROLL = 1
) (
   input logic                       clock_i,
   input logic                       reset_i,
   ascon_permutation_iter_if.slave   perm
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_t;

   fsm_t       fsm_r;
   type_state  state_r;
   logic [3:0] round_r;
   logic       busy_r;
   logic       done_r;
   logic       pend_r;

   type_state  next_state_s;
   logic [3:0] step_s;
   logic [3:0] remain_s;
   logic [3:0] n_eff_s;

   function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (32'd64 - n));
   endfunction

   // One full round: constant addition, bit-sliced 5-bit S-box, linear diffusion.
   function automatic type_state ascon_round(input type_state s, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      type_state   a;
      x0 = s[0];
      x1 = s[1];
      x2 = s[2] ^ {56'd0, 4'hF - r, r};
      x3 = s[3];
      x4 = s[4];
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      a[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
      a[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
      a[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
      a[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
      a[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
      return a;
   endfunction

   // Round chain for one clock: up to UNROLL rounds, truncated at round index 12.
   always_comb begin
      type_state cur;
      n_eff_s  = (perm.rounds_i > 4'd12) ? 4'd12 : perm.rounds_i;
      remain_s = 4'd12 - round_r;
      step_s   = (remain_s < 4'(UNROLL)) ? remain_s : 4'(UNROLL);
      cur      = state_r;
      for (int j = 0; j < 4; j++) begin
         if ((j < UNROLL) && (4'(j) < step_s)) begin
            cur = ascon_round(cur, round_r + 4'(j));
         end else begin
            cur = cur;
         end
      end
      next_state_s = cur;
   end

   // Control FSM and all output registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm_r   <= ST_IDLE;
         state_r <= '0;
         round_r <= 4'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pend_r  <= 1'b0;
      end else begin
         case (fsm_r)
            ST_IDLE, ST_DONE: begin
               // pend_r carries the deferred done pulse of a zero-round start.
               done_r <= pend_r;
               pend_r <= 1'b0;
               if (perm.start_i) begin
                  state_r <= perm.state_i;
                  round_r <= 4'd12 - n_eff_s;
                  done_r  <= 1'b0;
                  if (n_eff_s != 4'd0) begin
                     busy_r <= 1'b1;
                     fsm_r  <= ST_RUN;
                  end else begin
                     pend_r <= 1'b1;
                     fsm_r  <= ST_DONE;
                  end
               end
            end
            ST_RUN: begin
               // The done cycle is still spent in RUN so a start coinciding with done_o is dropped.
               if (round_r != 4'd12) begin
                  state_r <= next_state_s;
                  round_r <= round_r + step_s;
               end else if (!done_r) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end else begin
                  done_r <= 1'b0;
                  fsm_r  <= ST_DONE;
               end
            end
            default: begin
               fsm_r  <= ST_IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
               pend_r <= 1'b0;
            end
         endcase
      end
   end

   assign perm.state_o = state_r;
   assign perm.round_o = round_r;
   assign perm.busy_o  = busy_r;
   assign perm.done_o  = done_r;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Randomized self-checking bench: UNROLL=1 and UNROLL=4 engines run side by side
// against a table-driven column S-box reference model.
module tb_ascon_permutation_iter;
   import ascon_pack::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ascon_permutation_iter_if if1();
   ascon_permutation_iter_if if4();

   ascon_permutation_iter #(.UNROLL(1)) dut1 (.clock_i(clk), .reset_i(rst), .perm(if1));
   ascon_permutation_iter #(.UNROLL(4)) dut4 (.clock_i(clk), .reset_i(rst), .perm(if4));

   byte unsigned sbox_tab [32] = '{
      8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
      8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
      8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
      8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17};

   task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rot(input logic [63:0] x, input int n);
      logic [127:0] d;
      d = {x, x} >> n;
      return d[63:0];
   endfunction

   function automatic type_state model_round(input type_state s, input int r);
      type_state    t;
      int           idx;
      byte unsigned o;
      int           amt [5][2] = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};
      s[2] = s[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
         idx = 0;
         for (int i = 0; i < 5; i++) idx = idx * 2 + int'(s[i][b]);
         o = sbox_tab[idx];
         for (int i = 0; i < 5; i++) t[i][b] = o[4 - i];
      end
      for (int i = 0; i < 5; i++) s[i] = t[i] ^ rot(t[i], amt[i][0]) ^ rot(t[i], amt[i][1]);
      return s;
   endfunction

   function automatic type_state model_perm(input type_state s, input int first, input int cnt);
      for (int k = 0; k < cnt; k++) s = model_round(s, first + k);
      return s;
   endfunction

   // Start both engines together; optionally poke a stray start into the UNROLL=1 engine.
   task automatic run_case(input string tag, input logic [3:0] n, input type_state s, input int inject);
      int        neff, lat1, lat4, done1, done4;
      type_state exp;
      neff  = (n > 4'd12) ? 12 : int'(n);
      exp   = model_perm(s, 12 - neff, neff);
      lat1  = -1;
      lat4  = -1;
      done1 = 0;
      done4 = 0;
      @(negedge clk);
      if1.start_i = 1'b1; if1.rounds_i = n; if1.state_i = s;
      if4.start_i = 1'b1; if4.rounds_i = n; if4.state_i = s;
      @(negedge clk);
      if1.start_i = 1'b0;
      if4.start_i = 1'b0;
      check_eq({tag, ":first_round"}, 320'(if1.round_o), 320'(12 - neff));
      check_eq({tag, ":busy_after_start"}, 320'(if1.busy_o), 320'(neff != 0));
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (if1.done_o) begin done1++; if (lat1 < 0) lat1 = cyc; end
         if (if4.done_o) begin done4++; if (lat4 < 0) lat4 = cyc; end
         if (cyc <= neff) begin
            check_eq($sformatf("%s:step%0d_state", tag, cyc), if1.state_o,
                     model_perm(s, 12 - neff, cyc));
            check_eq($sformatf("%s:step%0d_round", tag, cyc), 320'(if1.round_o),
                     320'(12 - neff + cyc));
         end
         if1.start_i = (cyc == inject);
         if (cyc == inject) begin
            if1.rounds_i = 4'd1;
            if1.state_i  = ~s;
         end
      end
      if1.start_i = 1'b0;
      check_eq({tag, ":latency_u1"}, 320'(lat1), 320'(neff + 1));
      check_eq({tag, ":latency_u4"}, 320'(lat4), 320'((neff + 3) / 4 + 1));
      check_eq({tag, ":done_pulses_u1"}, 320'(done1), 320'(1));
      check_eq({tag, ":done_pulses_u4"}, 320'(done4), 320'(1));
      check_eq({tag, ":result_u1"}, if1.state_o, exp);
      check_eq({tag, ":result_u4"}, if4.state_o, exp);
      check_eq({tag, ":final_round"}, 320'(if1.round_o), 320'(12));
      check_eq({tag, ":busy_end"}, 320'(if1.busy_o), 320'(0));
   endtask

   task automatic check_cleared(input string tag);
      check_eq({tag, ":state"}, {if1.state_o, if4.state_o}, 640'd0);
      check_eq({tag, ":round"}, 320'({if1.round_o, if4.round_o}), 320'(0));
      check_eq({tag, ":busy"},  320'({if1.busy_o, if4.busy_o}), 320'(0));
      check_eq({tag, ":done"},  320'({if1.done_o, if4.done_o}), 320'(0));
   endtask

   type_state iv;
   type_state rs;
   int        stray;

   initial begin
      rst = 1'b1;
      if1.start_i = 1'b0; if1.rounds_i = 4'd0; if1.state_i = '0;
      if4.start_i = 1'b0; if4.rounds_i = 4'd0; if4.state_i = '0;
      iv[0] = 64'h80400c0600000000;
      iv[1] = 64'h8a55114d1cb6a9a2;
      iv[2] = 64'hbe263d4d7aecaaff;
      iv[3] = 64'h4ed0ec0b98c529b7;
      iv[4] = 64'hc8cddf37bcd0284a;

      repeat (3) @(negedge clk);
      check_cleared("reset");
      rst = 1'b0;

      run_case("p12", 4'd12, iv, 0);
      run_case("p6", 4'd6, iv, 0);
      run_case("p8", 4'd8, iv, 0);
      run_case("start_while_busy", 4'd12, iv, 5);
      run_case("start_on_done", 4'd12, iv, 13);
      run_case("bypass", 4'd0, iv, 0);
      run_case("clamp15", 4'd15, iv, 0);
      run_case("clamp13", 4'd13, iv, 0);

      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < 5; i++) rs[i] = {$urandom, $urandom};
         run_case($sformatf("rand%0d", it), 4'($urandom_range(0, 15)), rs, 0);
      end

      // Reset four cycles into a run must abort it without a done pulse.
      @(negedge clk);
      if1.start_i = 1'b1; if1.rounds_i = 4'd12; if1.state_i = iv;
      if4.start_i = 1'b1; if4.rounds_i = 4'd12; if4.state_i = iv;
      @(negedge clk);
      if1.start_i = 1'b0;
      if4.start_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_cleared("midrun_reset");
      rst = 1'b0;
      stray = 0;
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(negedge clk);
         if (if1.done_o || if4.done_o) stray++;
      end
      check_eq("midrun_reset:no_done", 320'(stray), 320'(0));
      run_case("p12_after_reset", 4'd12, iv, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
